seq_detect_sched: RTL and testbench

Time-multiplexed overlapping serial pattern detector shared among NCH independent serial bit streams. A round-robin scheduler grants at most one channel per cycle to a single shared match datapath. Per-channel context (bit history and fill count) is saved and restored around each evaluation. Sits between the serial front-end channels and the event/interrupt logic, and replaces NCH copies of a per-stream Moore detector.

---
 rtl/seq_detect_sched.sv | 154 +++++++++++++++
 tb/tb_seq_detect_sched.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_sched.sv
// seq_detect_sched: one shared overlapping serial pattern matcher, time-multiplexed
// across NCH serial channels by a round-robin arbiter. Each channel keeps its own
// bit history and fill count, which the matcher reads and updates only when that
// channel is granted.
// Optional feature: define SEQ_SCHED_HITCNT_EN to add per-channel 8-bit saturating
// hit counters and the hit_cnt port.
module seq_detect_sched #(
  parameter int              NCH     = 4,
  parameter int              PLEN    = 4,
  parameter logic [PLEN-1:0] PATTERN = 4'b1010
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCH-1:0]           in_valid,
  input  logic [NCH-1:0]           in_bit,
  output logic [NCH-1:0]           in_ready,
  input  logic [NCH-1:0]           ch_clr,
  output logic                     hit_valid,
  output logic [$clog2(NCH)-1:0]   hit_ch
`ifdef SEQ_SCHED_HITCNT_EN
  ,
  output logic [8*NCH-1:0]         hit_cnt
`endif
);

  localparam int IW = $clog2(NCH);
  localparam int FW = $clog2(PLEN + 1);

  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PLEN-1:0] hist_q [NCH];
  logic [PLEN-1:0] hist_d [NCH];
  logic [FW-1:0]   fill_q [NCH];
  logic [FW-1:0]   fill_d [NCH];
  logic            hit_valid_q, hit_valid_d;
  logic [IW-1:0]   hit_ch_q, hit_ch_d;

  logic [NCH-1:0]  eligible;
  logic [NCH-1:0]  grant;
  logic            grant_any;
  logic [IW-1:0]   grant_idx;
  logic [IW-1:0]   scan_idx;
  logic [PLEN-1:0] new_hist;
  logic [FW-1:0]   new_fill;

  // Round-robin arbiter: scan from the slot after the last grant, first eligible wins.
  // Requests are also gated by rst_n so nothing is granted while reset is held.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    eligible  = in_valid & ~ch_clr & {NCH{rst_n}};
    for (int k = 1; k <= NCH; k++) begin
      scan_idx = IW'((int'(rr_ptr_q) + k) % NCH);
      if (!grant_any && eligible[scan_idx]) begin
        grant[scan_idx] = 1'b1;
        grant_any       = 1'b1;
        grant_idx       = scan_idx;
      end
    end
  end

  assign in_ready = grant;

  // Shared matcher: shift the granted bit into its channel's context and test for a hit.
  always_comb begin
    hist_d      = hist_q;
    fill_d      = fill_q;
    rr_ptr_d    = rr_ptr_q;
    hit_valid_d = 1'b0;
    hit_ch_d    = hit_ch_q;
    new_hist    = {hist_q[grant_idx][PLEN-2:0], in_bit[grant_idx]};
    new_fill    = (fill_q[grant_idx] == FW'(PLEN)) ? fill_q[grant_idx]
                                                   : fill_q[grant_idx] + FW'(1);
    for (int i = 0; i < NCH; i++) begin
      if (ch_clr[i]) begin
        hist_d[i] = '0;
        fill_d[i] = '0;
      end
    end
    if (grant_any) begin
      hist_d[grant_idx] = new_hist;
      fill_d[grant_idx] = new_fill;
      rr_ptr_d          = grant_idx;
      if ((new_hist == PATTERN) && (new_fill == FW'(PLEN))) begin
        hit_valid_d = 1'b1;
        hit_ch_d    = grant_idx;
      end
    end
  end

  // Context, arbiter pointer and hit register; pointer resets to NCH-1 so ch0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= IW'(NCH - 1);
      hit_valid_q <= 1'b0;
      hit_ch_q    <= '0;
      for (int i = 0; i < NCH; i++) begin
        hist_q[i] <= '0;
        fill_q[i] <= '0;
      end
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      hit_valid_q <= hit_valid_d;
      hit_ch_q    <= hit_ch_d;
      for (int i = 0; i < NCH; i++) begin
        hist_q[i] <= hist_d[i];
        fill_q[i] <= fill_d[i];
      end
    end
  end

  assign hit_valid = hit_valid_q;
  assign hit_ch    = hit_ch_q;

`ifdef SEQ_SCHED_HITCNT_EN
  logic [7:0] cnt_q [NCH];
  logic [7:0] cnt_d [NCH];

  // Per-channel saturating hit counters; a clear on the same edge beats a hit.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NCH; i++) begin
      if (ch_clr[i]) begin
        cnt_d[i] = '0;
      end else if (hit_valid_d && (hit_ch_d == IW'(i)) && (cnt_q[i] != 8'hFF)) begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Pack counters onto the flat output, ch0 in the low byte.
  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      hit_cnt[8*i +: 8] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_seq_detect_sched.sv
// Directed testbench for seq_detect_sched (NCH=4, PLEN=4, PATTERN=1010).
// Counter checks are compiled in only when SEQ_SCHED_HITCNT_EN is defined.
module tb_seq_detect_sched;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_valid;
  logic [3:0] in_bit;
  logic [3:0] in_ready;
  logic [3:0] ch_clr;
  logic       hit_valid;
  logic [1:0] hit_ch;
`ifdef SEQ_SCHED_HITCNT_EN
  logic [31:0] hit_cnt;
`endif

  int checks;
  int errors;

  seq_detect_sched #(
    .NCH    (4),
    .PLEN   (4),
    .PATTERN(4'b1010)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_ready (in_ready),
    .ch_clr   (ch_clr),
    .hit_valid(hit_valid),
    .hit_ch   (hit_ch)
`ifdef SEQ_SCHED_HITCNT_EN
    ,
    .hit_cnt  (hit_cnt)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = '0;
    in_bit   = '0;
    ch_clr   = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 4'hF;
    in_bit   = '0;
    ch_clr   = '0;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_ready got %b exp 0000", in_ready);
    end
    tick();
    checks++;
    if (hit_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hit_valid got %b exp 0", hit_valid);
    end
    checks++;
    if (hit_ch !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_hit_ch got %0d exp 0", hit_ch);
    end
`ifdef SEQ_SCHED_HITCNT_EN
    checks++;
    if (hit_cnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_hit_cnt got %h exp 0", hit_cnt);
    end
`endif
    in_valid = '0;
    rst_n    = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL idle_ready got %b exp 0000", in_ready);
    end
    in_valid = 4'hF;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL first_grant got %b exp 0001", in_ready);
    end
    in_valid = '0;
  endtask

  task automatic test_single();
    logic [5:0] seq;
    logic       exp_hit;
    seq = 6'b101010;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      in_valid = 4'b0001;
      in_bit   = {3'b000, seq[5-k]};
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin
        errors++;
        $display("[TB] FAIL single_ready k=%0d got %b exp 0001", k, in_ready);
      end
      tick();
      exp_hit = (k == 3) || (k == 5);
      checks++;
      if (hit_valid !== exp_hit) begin
        errors++;
        $display("[TB] FAIL single_hit k=%0d got %b exp %b", k, hit_valid, exp_hit);
      end
      if (exp_hit) begin
        checks++;
        if (hit_ch !== 2'd0) begin
          errors++;
          $display("[TB] FAIL single_hit_ch k=%0d got %0d exp 0", k, hit_ch);
        end
      end
    end
    in_valid = '0;
`ifdef SEQ_SCHED_HITCNT_EN
    checks++;
    if (hit_cnt[7:0] !== 8'd2) begin
      errors++;
      $display("[TB] FAIL single_cnt got %0d exp 2", hit_cnt[7:0]);
    end
`endif
  endtask

  task automatic test_fairness();
    logic [3:0] exp_rdy;
    do_reset();
    in_valid = 4'hF;
    in_bit   = 4'h0;
    for (int k = 0; k < 8; k++) begin
      exp_rdy = 4'(1 << (k % 4));
      #1;
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("[TB] FAIL rr_grant k=%0d got %b exp %b", k, in_ready, exp_rdy);
      end
      tick();
      checks++;
      if (hit_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rr_no_hit k=%0d got %b exp 0", k, hit_valid);
      end
    end
    in_valid = '0;
  endtask

  task automatic test_interleave();
    logic [3:0] p1;
    logic [3:0] p2;
    logic [3:0] exp_rdy;
    logic       exp_hit;
    int         c1;
    int         c2;
    p1 = 4'b1010;
    p2 = 4'b1011;
    c1 = 0;
    c2 = 0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      in_valid = {1'b0, (c2 < 4), (c1 < 4), 1'b0};
      in_bit   = '0;
      if (c1 < 4) in_bit[1] = p1[3-c1];
      if (c2 < 4) in_bit[2] = p2[3-c2];
      exp_rdy = (k % 2 == 0) ? 4'b0010 : 4'b0100;
      #1;
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("[TB] FAIL ilv_grant k=%0d got %b exp %b", k, in_ready, exp_rdy);
      end
      tick();
      if (k % 2 == 0) c1++;
      else            c2++;
      exp_hit = (k == 6);
      checks++;
      if (hit_valid !== exp_hit) begin
        errors++;
        $display("[TB] FAIL ilv_hit k=%0d got %b exp %b", k, hit_valid, exp_hit);
      end
      if (exp_hit) begin
        checks++;
        if (hit_ch !== 2'd1) begin
          errors++;
          $display("[TB] FAIL ilv_hit_ch got %0d exp 1", hit_ch);
        end
      end
    end
    in_valid = '0;
  endtask

  task automatic test_clear();
    logic [2:0] pre;
    logic [4:0] post;
    logic       exp_hit;
    pre  = 3'b101;
    post = 5'b01010;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      in_valid = 4'b1000;
      in_bit   = {pre[2-k], 3'b000};
      #1;
      checks++;
      if (in_ready !== 4'b1000) begin
        errors++;
        $display("[TB] FAIL clr_pre_ready k=%0d got %b exp 1000", k, in_ready);
      end
      tick();
    end
    ch_clr   = 4'b1000;
    in_valid = 4'b1000;
    in_bit   = 4'b0000;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL clr_mask got %b exp 0000", in_ready);
    end
    tick();
    checks++;
    if (hit_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clr_no_hit got %b exp 0", hit_valid);
    end
    ch_clr = '0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 4'b1000;
      in_bit   = {post[4-k], 3'b000};
      tick();
      exp_hit = (k == 4);
      checks++;
      if (hit_valid !== exp_hit) begin
        errors++;
        $display("[TB] FAIL clr_post_hit k=%0d got %b exp %b", k, hit_valid, exp_hit);
      end
    end
    in_valid = '0;
    checks++;
    if (hit_ch !== 2'd3) begin
      errors++;
      $display("[TB] FAIL clr_hit_ch got %0d exp 3", hit_ch);
    end
`ifdef SEQ_SCHED_HITCNT_EN
    checks++;
    if (hit_cnt[31:24] !== 8'd1) begin
      errors++;
      $display("[TB] FAIL clr_cnt got %0d exp 1", hit_cnt[31:24]);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [2:0] pre;
    pre = 3'b101;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      in_valid = 4'b0001;
      in_bit   = {3'b000, pre[2-k]};
      tick();
    end
    rst_n    = 1'b0;
    in_valid = 4'b0001;
    in_bit   = 4'b0000;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL rmid_ready got %b exp 0000", in_ready);
    end
    checks++;
    if (hit_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rmid_hit_in_reset got %b exp 0", hit_valid);
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL rmid_ready_after got %b exp 0001", in_ready);
    end
    tick();
    checks++;
    if (hit_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rmid_no_hit got %b exp 0", hit_valid);
    end
    in_valid = '0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat;
    logic       exp_hit;
    logic [1:0] exp_ch;
    int         c0;
    int         c1;
    pat = 4'b1010;
    c0  = 0;
    c1  = 0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      in_valid = 4'b0011;
      in_bit   = {2'b00, pat[3-c1], pat[3-c0]};
      tick();
      if (k % 2 == 0) c0++;
      else            c1++;
      exp_hit = (k >= 6);
      exp_ch  = (k == 6) ? 2'd0 : 2'd1;
      checks++;
      if (hit_valid !== exp_hit) begin
        errors++;
        $display("[TB] FAIL b2b_hit k=%0d got %b exp %b", k, hit_valid, exp_hit);
      end
      if (exp_hit) begin
        checks++;
        if (hit_ch !== exp_ch) begin
          errors++;
          $display("[TB] FAIL b2b_hit_ch k=%0d got %0d exp %0d", k, hit_ch, exp_ch);
        end
      end
    end
    in_valid = '0;
    tick();
    checks++;
    if (hit_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_pulse got %b exp 0", hit_valid);
    end
    checks++;
    if (hit_ch !== 2'd1) begin
      errors++;
      $display("[TB] FAIL b2b_hold_ch got %0d exp 1", hit_ch);
    end
  endtask

`ifdef SEQ_SCHED_HITCNT_EN
  task automatic test_saturation();
    logic exp_hit;
    int   seen;
    seen = 0;
    do_reset();
    for (int j = 0; j < 602; j++) begin
      in_valid = 4'b0010;
      in_bit   = {2'b00, (j % 2 == 0), 1'b0};
      tick();
      exp_hit = (j % 2 == 1) && (j >= 3);
      if (hit_valid === 1'b1) seen++;
      checks++;
      if (hit_valid !== exp_hit) begin
        errors++;
        $display("[TB] FAIL sat_hit j=%0d got %b exp %b", j, hit_valid, exp_hit);
      end
    end
    in_valid = '0;
    checks++;
    if (seen != 300) begin
      errors++;
      $display("[TB] FAIL sat_pulses got %0d exp 300", seen);
    end
    checks++;
    if (hit_cnt[15:8] !== 8'd255) begin
      errors++;
      $display("[TB] FAIL sat_cnt got %0d exp 255", hit_cnt[15:8]);
    end
  endtask
`endif

  // Run every scenario in order, then report.
  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    in_valid = '0;
    in_bit   = '0;
    ch_clr   = '0;
    test_reset();
    test_single();
    test_fairness();
    test_interleave();
    test_clear();
    test_reset_mid();
    test_back_to_back();
`ifdef SEQ_SCHED_HITCNT_EN
    test_saturation();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
